bsg_trace_mem_loader: RTL and testbench
=======================================

Name: bsg_trace_mem_loader

Overview:
- Runtime-loadable trace memory that replaces the static trace ROM in front of the trace replay engine.
- Receives trace entries (4-bit opcode on top, payload below) as narrow chunks over a valid/ready channel and assembles them into full entries.
- Stores entries in an internal register array and serves asynchronous reads on the replay engine's ROM address.
- Holds the replay engine disabled until loading completes, so one bench binary can run many traces without recompiling.

Parameters:
- width_p, 84: full trace entry width (payload + 4-bit opcode); opcode occupies [width_p-1 -: 4].
- els_p, 64: number of entries; must be >= 2.
- chunk_width_p, 32: width of each load chunk; must be >= 1.
- addr_width_lp, `BSG_SAFE_CLOG2(els_p): ROM address width (localparam).
- chunks_lp, ceil(width_p/chunk_width_p): chunks per entry (localparam).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset; one clock; reset is asynchronous and active-high.
- v_i  in  1  load chunk valid.
- data_i  in  chunk_width_p  load chunk, least-significant chunk of an entry first.
- last_i  in  1  marks the final entry of the trace; sampled only on an entry's final chunk.
- ready_and_o  out  1  load channel ready; handshake is v_i & ready_and_o.
- reload_i  in  1  single-cycle request to discard contents and re-enter loading.
- rom_addr_i  in  addr_width_lp  read address from the replay engine.
- rom_data_o  out  width_p  combinational read data.
- en_o  out  1  replay enable; high only in RUN.
- count_o  out  addr_width_lp+1  number of valid entries loaded.
- overflow_o  out  1  sticky; memory filled before last_i was seen.

Behaviour:
- Reset values: state=LOAD, ready_and_o=1, en_o=0, count_o=0, overflow_o=0, chunk counter=0, assembly register=0. Array contents are not reset.
- FSM LOAD:
  - ready_and_o=1.
  - Each handshake stores data_i into chunk slot chunk_cnt of the assembly register and increments chunk_cnt.
  - On the final chunk (chunk_cnt==chunks_lp-1), only the low width_p-(chunks_lp-1)*chunk_width_p bits are used; upper bits are ignored.
  - At the edge of the final-chunk handshake:
    - the full entry is written to array[count_o];
    - count_o is incremented;
    - chunk_cnt returns to 0.
  - last_i on a non-final chunk is ignored.
- LOAD -> RUN, at the final-chunk edge, when either:
  - last_i=1; or
  - count_o reaches els_p. In this case overflow_o is also set if last_i=0.
  - en_o rises the cycle after the transition edge. Zero-latency write: the entry is readable the cycle after its final chunk.
- FSM RUN:
  - ready_and_o=0, en_o=1.
  - Array is read-only.
- reload_i, in any state:
  - next state LOAD; count_o, chunk_cnt and overflow_o cleared; en_o low the next cycle.
  - reload_i wins over a simultaneous handshake; that chunk and any partial entry are discarded.
- Read path (combinational, no latency):
  - if rom_addr_i < count_o: rom_data_o = array[rom_addr_i];
  - otherwise: rom_data_o = FINISH_WORD, opcode 4'd4 (finish) with zero payload. Out-of-range or unloaded addresses therefore terminate replay cleanly.
- Asynchronous reset mid-load: partial entry lost, state LOAD immediately, count_o=0.
- Widths: count_o compared with zero-extended rom_addr_i. Address arithmetic never wraps, because LOAD exits at count_o==els_p.

Decomposition:
- Shared package bsg_trace_pkg:
  - opcode enum (eNop=0, eSend=1, eReceive=2, eDone=3, eFinish=4, eCycleDec=5, eCycleInit=6);
  - opcode width constant (4);
  - loader state enum (eLoad, eRun).
  - The replay engine imports the same opcode enum.
- Sub-module bsg_trace_word_assembler:
  - chunk counter + assembly register;
  - outputs word valid, assembled word and a final-chunk indicator;
  - parameterised by width_p and chunk_width_p.

Test Plan (defaults: width_p=84, chunk_width_p=32, chunks_lp=3):
- Basic load: send entry {4'h1, 80'hA5...A5} as 3 chunks with last_i=1 on the third -> en_o=1 the next cycle; count_o=1; rom_addr_i=0 returns that entry; rom_addr_i=1 returns {4'h4, 80'h0}.
- Upper-bit discard: third chunk = 32'hFFFFFFFF -> stored bits [83:64] = 20'hFFFFF; no other bits are affected.
- Overflow: els_p=4, four entries with last_i=0 -> RUN after the fourth entry; overflow_o=1; count_o=4; ready_and_o=0.
- Backpressure/stall: v_i toggled 1,0,1,0,1 across one entry -> exactly one write, after the third accepted chunk.
- Reload collision: reload_i in the same cycle as the final chunk of entry 2 -> count_o=0, state LOAD, entry not written; reload in RUN drops en_o next cycle.
- Async reset after 2 of 3 chunks -> outputs at reset values immediately. A subsequent full 3-chunk entry is stored intact with no stale slot data.

Source files
------------

// File: rtl/bsg_trace_pkg.sv
// Shared definitions for the trace replay engine and its runtime-loadable trace memory.
package bsg_trace_pkg;

    localparam int op_width_gp = 4;

    typedef enum logic [op_width_gp-1:0] {
        eNop       = 4'd0,
        eSend      = 4'd1,
        eReceive   = 4'd2,
        eDone      = 4'd3,
        eFinish    = 4'd4,
        eCycleDec  = 4'd5,
        eCycleInit = 4'd6
    } bsg_trace_op_e;

    typedef enum logic {
        eLoad,
        eRun
    } bsg_trace_loader_state_e;

    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bsg_trace_word_assembler.sv
// Collects chunk_width_p-wide chunks (least-significant first) into one width_p-wide entry.
module bsg_trace_word_assembler
    import bsg_trace_pkg::*;
#(
    parameter int width_p       = 84,
    parameter int chunk_width_p = 32
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     clear_i,
    input  logic                     v_i,
    input  logic [chunk_width_p-1:0] data_i,
    output logic                     v_o,
    output logic [width_p-1:0]       data_o,
    output logic                     final_o
);

    localparam int chunks_lp    = (width_p + chunk_width_p - 1) / chunk_width_p;
    localparam int cnt_width_lp = safe_clog2(chunks_lp);
    localparam int low_width_lp = (chunks_lp - 1) * chunk_width_p;
    localparam int top_width_lp = width_p - low_width_lp;
    localparam logic [cnt_width_lp-1:0] final_cnt_lp = cnt_width_lp'(chunks_lp - 1);

    logic [cnt_width_lp-1:0] cnt_r;

    assign final_o = (cnt_r == final_cnt_lp);
    assign v_o     = v_i & final_o;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            cnt_r <= '0;
        else if (clear_i)
            cnt_r <= '0;
        else if (v_i)
            cnt_r <= final_o ? '0 : cnt_r + 1'b1;
    end

    // The final chunk bypasses the register so the entry can be written on its own edge.
    if (chunks_lp > 1) begin : g_multi
        logic [low_width_lp-1:0] low_r;

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                low_r <= '0;
            end else if (v_i && !final_o) begin
                for (int k = 0; k < chunks_lp - 1; k++)
                    if (cnt_r == cnt_width_lp'(k))
                        low_r[k*chunk_width_p +: chunk_width_p] <= data_i;
            end
        end

        assign data_o = {data_i[top_width_lp-1:0], low_r};
    end else begin : g_single
        assign data_o = data_i[width_p-1:0];
    end

endmodule

// File: rtl/bsg_trace_mem_loader.sv
// Runtime-loadable trace memory: assembles chunked entries, then enables replay and serves
// combinational reads; unloaded addresses read back as a finish opcode.
module bsg_trace_mem_loader
    import bsg_trace_pkg::*;
#(
    parameter  int width_p       = 84,
    parameter  int els_p         = 64,
    parameter  int chunk_width_p = 32,
    localparam int addr_width_lp = safe_clog2(els_p)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     v_i,
    input  logic [chunk_width_p-1:0] data_i,
    input  logic                     last_i,
    output logic                     ready_and_o,
    input  logic                     reload_i,
    input  logic [addr_width_lp-1:0] rom_addr_i,
    output logic [width_p-1:0]       rom_data_o,
    output logic                     en_o,
    output logic [addr_width_lp:0]   count_o,
    output logic                     overflow_o
);

    localparam logic [width_p-1:0] finish_word_lp =
        {eFinish, {(width_p-op_width_gp){1'b0}}};
    localparam logic [addr_width_lp:0] last_idx_lp = (addr_width_lp+1)'(els_p - 1);

    bsg_trace_loader_state_e state_r, state_n;
    logic [addr_width_lp:0]  count_r;
    logic                    overflow_r;
    logic                    accept;
    logic                    word_v;
    logic [width_p-1:0]      word;
    logic                    final_chunk;
    logic                    mem_full;
    logic [width_p-1:0]      mem_r [els_p];

    assign ready_and_o = (state_r == eLoad);
    assign en_o        = (state_r == eRun);
    assign count_o     = count_r;
    assign overflow_o  = overflow_r;
    assign accept      = v_i & ready_and_o & ~reload_i;
    assign mem_full    = (count_r == last_idx_lp);

    bsg_trace_word_assembler #(
        .width_p      (width_p),
        .chunk_width_p(chunk_width_p)
    ) assembler (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .clear_i(reload_i),
        .v_i    (accept),
        .data_i (data_i),
        .v_o    (word_v),
        .data_o (word),
        .final_o(final_chunk)
    );

    always_comb begin
        state_n = state_r;
        if (reload_i)
            state_n = eLoad;
        else if (state_r == eLoad && word_v && (last_i || mem_full))
            state_n = eRun;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r    <= eLoad;
            count_r    <= '0;
            overflow_r <= 1'b0;
        end else begin
            state_r <= state_n;
            if (reload_i) begin
                count_r    <= '0;
                overflow_r <= 1'b0;
            end else if (word_v) begin
                count_r <= count_r + 1'b1;
                if (mem_full && !last_i)
                    overflow_r <= 1'b1;
            end
        end
    end

    // Contents are deliberately not reset; count_r alone decides what is visible.
    always_ff @(posedge clk_i) begin
        if (word_v)
            mem_r[count_r[addr_width_lp-1:0]] <= word;
    end

    assign rom_data_o = ({1'b0, rom_addr_i} < count_r) ? mem_r[rom_addr_i] : finish_word_lp;

endmodule

// File: tb/tb_bsg_trace_mem_loader.sv
// Bench for bsg_trace_mem_loader: table-driven overflow load plus directed multi-cycle cases.
module tb_bsg_trace_mem_loader;

    localparam int W  = 84;
    localparam int E  = 4;
    localparam int CW = 32;
    localparam int AW = 2;

    localparam logic [W-1:0] FINISH = {4'h4, 80'h0};

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          v = 1'b0;
    logic [CW-1:0] data = '0;
    logic          last = 1'b0;
    logic          ready;
    logic          reload = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [W-1:0]  rdata;
    logic          en;
    logic [AW:0]   count;
    logic          ovf;

    int n_vec  = 0;
    int n_fail = 0;

    logic [W-1:0] sb_q[$];

    typedef struct {
        logic [W-1:0] word;
        logic         last;
        logic [AW:0]  exp_count;
        logic         exp_en;
        logic         exp_ovf;
    } vec_t;

    vec_t tbl[E];

    always #5 clk = ~clk;

    bsg_trace_mem_loader #(
        .width_p      (W),
        .els_p        (E),
        .chunk_width_p(CW)
    ) dut (
        .clk_i      (clk),
        .reset_i    (rst),
        .v_i        (v),
        .data_i     (data),
        .last_i     (last),
        .ready_and_o(ready),
        .reload_i   (reload),
        .rom_addr_i (addr),
        .rom_data_o (rdata),
        .en_o       (en),
        .count_o    (count),
        .overflow_o (ovf)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] chunk_of(input logic [W-1:0] w, input int c);
        logic [3*CW-1:0] x;
        x = {{(3*CW-W){1'b0}}, w};
        return x[c*CW +: CW];
    endfunction

    task automatic send_chunk(input logic [CW-1:0] d, input logic lst, input logic rl);
        @(negedge clk);
        v = 1'b1; data = d; last = lst; reload = rl;
        @(posedge clk);
        #1;
        v = 1'b0; last = 1'b0; reload = 1'b0;
    endtask

    // last_i is held on every chunk so a non-final last_i must be ignored.
    task automatic send_entry(input logic [W-1:0] w, input logic lst);
        for (int c = 0; c < 3; c++)
            send_chunk(chunk_of(w, c), lst, 1'b0);
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [AW-1:0] a, input logic [W-1:0] exp);
        addr = a;
        #1;
        check(name, rdata, exp);
    endtask

    task automatic drain_scoreboard(input string name);
        int a;
        a = 0;
        while (sb_q.size() > 0) begin
            read_check(name, AW'(a), sb_q.pop_front());
            a++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] e1, e2, e3, exp_w;
        logic [4:0]   stall_v;
        int           ci;

        e1 = {4'h1, {10{8'hA5}}};
        e2 = {4'h2, 80'h0123_4567_89AB_CDEF_0F1E};
        e3 = {4'h3, 80'h0000_1111_0000_2222_0000};
        tbl[0] = '{word: {4'h1, 80'hDEAD_BEEF_0000_0000_0001}, last: 1'b0, exp_count: 3'd1, exp_en: 1'b0, exp_ovf: 1'b0};
        tbl[1] = '{word: {4'h2, 80'h1234_5678_9ABC_DEF0_0002}, last: 1'b0, exp_count: 3'd2, exp_en: 1'b0, exp_ovf: 1'b0};
        tbl[2] = '{word: {4'h5, 80'hFFFF_0000_FFFF_0000_0003}, last: 1'b0, exp_count: 3'd3, exp_en: 1'b0, exp_ovf: 1'b0};
        tbl[3] = '{word: {4'h6, 80'h0F0F_F0F0_5A5A_A5A5_0004}, last: 1'b0, exp_count: 3'd4, exp_en: 1'b1, exp_ovf: 1'b1};

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", ready, 1);
        check("rst_en", en, 0);
        check("rst_count", count, 0);
        check("rst_ovf", ovf, 0);
        read_check("rst_read0", 0, FINISH);

        // basic load
        send_chunk(chunk_of(e1, 0), 1'b1, 1'b0);
        send_chunk(chunk_of(e1, 1), 1'b1, 1'b0);
        check("basic_count_partial", count, 0);
        check("basic_en_partial", en, 0);
        send_chunk(chunk_of(e1, 2), 1'b1, 1'b0);
        sb_q.push_back(e1);
        check("basic_en", en, 1);
        check("basic_count", count, 1);
        check("basic_ready", ready, 0);
        drain_scoreboard("basic_read0");
        read_check("basic_read1_finish", 1, FINISH);

        // reload from RUN
        pulse_reload();
        check("reload_run_en", en, 0);
        check("reload_run_count", count, 0);
        check("reload_run_ready", ready, 1);

        // upper-bit discard on the final chunk
        send_chunk(32'h1234_5678, 1'b1, 1'b0);
        send_chunk(32'h9ABC_DEF0, 1'b1, 1'b0);
        send_chunk(32'hFFFF_FFFF, 1'b1, 1'b0);
        exp_w = {20'hFFFFF, 32'h9ABC_DEF0, 32'h1234_5678};
        sb_q.push_back(exp_w);
        drain_scoreboard("discard_read0");
        pulse_reload();

        // stalls inside one entry
        stall_v = 5'b10101;
        ci = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            v = stall_v[4-i];
            data = chunk_of(e2, ci);
            @(posedge clk);
            #1;
            if (stall_v[4-i]) ci++;
            v = 1'b0;
            check($sformatf("stall_count_c%0d", i), count, (i == 4) ? 1 : 0);
        end
        sb_q.push_back(e2);
        check("stall_en", en, 0);
        drain_scoreboard("stall_read0");

        // reload collides with the final chunk of entry 2
        send_chunk(chunk_of(e3, 0), 1'b1, 1'b0);
        send_chunk(chunk_of(e3, 1), 1'b1, 1'b0);
        send_chunk(chunk_of(e3, 2), 1'b1, 1'b1);
        check("collide_count", count, 0);
        check("collide_ready", ready, 1);
        check("collide_en", en, 0);
        read_check("collide_read1", 1, FINISH);

        // async reset mid-entry
        send_entry(e2, 1'b0);
        send_chunk({CW{1'b1}}, 1'b0, 1'b0);
        send_chunk({CW{1'b1}}, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", count, 0);
        check("arst_ready", ready, 1);
        check("arst_en", en, 0);
        @(negedge clk);
        rst = 1'b0;
        send_entry(e3, 1'b1);
        sb_q.push_back(e3);
        check("arst_reload_count", count, 1);
        drain_scoreboard("arst_read0");
        pulse_reload();

        // overflow: table of entries, none marked last
        for (int i = 0; i < E; i++) begin
            send_entry(tbl[i].word, tbl[i].last);
            sb_q.push_back(tbl[i].word);
            check($sformatf("ovf_count_%0d", i), count, tbl[i].exp_count);
            check($sformatf("ovf_en_%0d", i), en, tbl[i].exp_en);
            check($sformatf("ovf_flag_%0d", i), ovf, tbl[i].exp_ovf);
        end
        check("ovf_ready", ready, 0);
        send_chunk(32'hCAFE_F00D, 1'b1, 1'b0);
        check("ovf_run_no_write", count, 4);
        drain_scoreboard("ovf_read");
        pulse_reload();
        check("ovf_reload_flag", ovf, 0);
        check("ovf_reload_count", count, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
